// File: rtl/washing_machine_ctrl_v2.sv
// Wash-cycle sequencer: FILL/WASH/RINSE(xN)/SPIN/DRY or STEAM_CLEAN, with pause and abort-to-drain.
// Advances on the 1 Hz tick clock; phase, repetition and remaining ticks feed the front panel.
module washing_machine_ctrl_v2 #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned FILL_TICKS  = 10,
    parameter int unsigned WASH_TICKS  = 50,
    parameter int unsigned RINSE_TICKS = 50,
    parameter int unsigned SPIN_TICKS  = 20,
    parameter int unsigned DRY_TICKS   = 60,
    parameter int unsigned STEAM_TICKS = 60,
    parameter int unsigned DRAIN_TICKS = 15,
    parameter int unsigned REP_W       = 2,
    parameter int unsigned MAX_REPS    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [REP_W-1:0] reps,
    input  logic             dry_wash,
    input  logic             time_pause,
    input  logic             abort,
    output logic             done,
    output logic             busy,
    output logic [2:0]       phase,
    output logic [REP_W-1:0] rep_idx,
    output logic [CNT_W-1:0] remaining
);

    function automatic bit in_range(longint unsigned val, int unsigned width);
        return (val >= 64'd1) && (val < (64'd1 << width));
    endfunction

    localparam bit PARAMS_OK =
        in_range(64'(FILL_TICKS), CNT_W)  && in_range(64'(WASH_TICKS), CNT_W)  &&
        in_range(64'(RINSE_TICKS), CNT_W) && in_range(64'(SPIN_TICKS), CNT_W)  &&
        in_range(64'(DRY_TICKS), CNT_W)   && in_range(64'(STEAM_TICKS), CNT_W) &&
        in_range(64'(DRAIN_TICKS), CNT_W) && in_range(64'(MAX_REPS), REP_W);

    if (!PARAMS_OK) begin : g_param_check
        $error("washing_machine_ctrl_v2: tick durations or MAX_REPS out of range");
    end

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        FILL        = 3'd1,
        WASH        = 3'd2,
        RINSE       = 3'd3,
        SPIN        = 3'd4,
        DRY         = 3'd5,
        STEAM_CLEAN = 3'd6,
        DRAIN       = 3'd7
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [REP_W-1:0]   rep_nxt;
    logic [REP_W-1:0]   reps_lat, reps_lat_nxt;
    logic [REP_W-1:0]   reps_clamped;
    logic               done_nxt;
    logic [CNT_W-1:0]   phase_len;
    logic               last_tick;
    logic               rep_more;

    // Duration of the current phase; IDLE has length 0 so remaining reads 0 there.
    always_comb begin
        phase_len = '0;
        case (state)
            FILL:        phase_len = CNT_W'(FILL_TICKS);
            WASH:        phase_len = CNT_W'(WASH_TICKS);
            RINSE:       phase_len = CNT_W'(RINSE_TICKS);
            SPIN:        phase_len = CNT_W'(SPIN_TICKS);
            DRY:         phase_len = CNT_W'(DRY_TICKS);
            STEAM_CLEAN: phase_len = CNT_W'(STEAM_TICKS);
            DRAIN:       phase_len = CNT_W'(DRAIN_TICKS);
            default:     phase_len = '0;
        endcase
    end

    always_comb begin
        reps_clamped = reps;
        if (reps == '0) begin
            reps_clamped = REP_W'(1);
        end else if (reps > REP_W'(MAX_REPS)) begin
            reps_clamped = REP_W'(MAX_REPS);
        end
    end

    assign last_tick = (cnt == (phase_len - CNT_W'(1)));
    assign rep_more  = (({1'b0, rep_idx} + (REP_W+1)'(1)) < {1'b0, reps_lat});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rep_idx  <= '0;
            reps_lat <= REP_W'(1);
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rep_idx  <= rep_nxt;
            reps_lat <= reps_lat_nxt;
            done     <= done_nxt;
        end
    end

    // Next-state: abort beats pause and the last-tick advance; DRAIN ignores both.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        rep_nxt      = rep_idx;
        reps_lat_nxt = reps_lat;
        done_nxt     = done;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                rep_nxt = '0;
                if (start) begin
                    reps_lat_nxt = reps_clamped;
                    done_nxt     = 1'b0;
                    state_nxt    = dry_wash ? STEAM_CLEAN : FILL;
                end
            end
            DRAIN: begin
                if (last_tick) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    rep_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                if (abort) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end else if (!time_pause) begin
                    if (!last_tick) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end else begin
                        cnt_nxt = '0;
                        case (state)
                            FILL:  state_nxt = WASH;
                            WASH:  state_nxt = RINSE;
                            RINSE: begin
                                if (rep_more) begin
                                    state_nxt = WASH;
                                    rep_nxt   = rep_idx + REP_W'(1);
                                end else begin
                                    state_nxt = SPIN;
                                end
                            end
                            SPIN:  state_nxt = DRY;
                            DRY, STEAM_CLEAN: begin
                                state_nxt = IDLE;
                                done_nxt  = 1'b1;
                                rep_nxt   = '0;
                            end
                            default: state_nxt = IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign phase     = 3'(state);
    assign remaining = phase_len - cnt;

endmodule

// File: tb/tb_washing_machine_ctrl_v2.sv
// Bench for washing_machine_ctrl_v2: constant vector table, directed timing sequences,
// and random stimulus against a segment-list model of the wash programme.
module tb_washing_machine_ctrl_v2;

    localparam int FILL_T  = 10;
    localparam int WASH_T  = 50;
    localparam int RINSE_T = 50;
    localparam int SPIN_T  = 20;
    localparam int DRY_T   = 60;
    localparam int STEAM_T = 60;
    localparam int DRAIN_T = 15;
    localparam int MAXR    = 3;

    logic        clk = 1'b0;
    logic        rst, start, dry_wash, time_pause, abort;
    logic [1:0]  reps;
    logic        done, busy, done2, busy2;
    logic [2:0]  phase, phase2;
    logic [1:0]  rep_idx, rep_idx2;
    logic [15:0] remaining, remaining2;

    washing_machine_ctrl_v2 dut (
        .clk(clk), .rst(rst), .start(start), .reps(reps), .dry_wash(dry_wash),
        .time_pause(time_pause), .abort(abort), .done(done), .busy(busy),
        .phase(phase), .rep_idx(rep_idx), .remaining(remaining)
    );

    washing_machine_ctrl_v2 #(.MAX_REPS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .reps(reps), .dry_wash(dry_wash),
        .time_pause(time_pause), .abort(abort), .done(done2), .busy(busy2),
        .phase(phase2), .rep_idx(rep_idx2), .remaining(remaining2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: the programme is a list of {phase, rep, length} segments consumed in order.
    typedef struct {
        int ph;
        int rep;
        int len;
    } seg_t;

    seg_t plan[$];
    int   m_el   = 0;
    bit   m_done = 1'b0;

    function automatic void model_reset();
        plan.delete();
        m_el   = 0;
        m_done = 1'b0;
    endfunction

    function automatic void model_step();
        if (rst) begin
            model_reset();
            return;
        end
        if (plan.size() == 0) begin
            if (start) begin
                int n;
                n = (reps == 0) ? 1 : ((int'(reps) > MAXR) ? MAXR : int'(reps));
                m_done = 1'b0;
                m_el   = 0;
                if (dry_wash) begin
                    plan.push_back('{6, 0, STEAM_T});
                end else begin
                    plan.push_back('{1, 0, FILL_T});
                    for (int r = 0; r < n; r++) begin
                        plan.push_back('{2, r, WASH_T});
                        plan.push_back('{3, r, RINSE_T});
                    end
                    plan.push_back('{4, n - 1, SPIN_T});
                    plan.push_back('{5, n - 1, DRY_T});
                end
            end
        end else if (abort && plan[0].ph != 7) begin
            int r;
            r = plan[0].rep;
            plan.delete();
            plan.push_back('{7, r, DRAIN_T});
            m_el = 0;
        end else if (plan[0].ph == 7 || !time_pause) begin
            m_el++;
            if (m_el == plan[0].len) begin
                int ph;
                ph = plan[0].ph;
                void'(plan.pop_front());
                m_el = 0;
                if (plan.size() == 0) m_done = (ph != 7);
            end
        end
    endfunction

    // Packed {phase, rep_idx, remaining, busy, done}.
    function automatic logic [22:0] model_out();
        if (plan.size() == 0) return {3'd0, 2'd0, 16'd0, 1'b0, m_done};
        return {3'(plan[0].ph), 2'(plan[0].rep), 16'(plan[0].len - m_el), 1'b1, m_done};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0d (0x%h) expected %0d (0x%h)", name, cyc, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        logic [22:0] a, e;
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        a = {phase, rep_idx, remaining, busy, done};
        e = model_out();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL model cyc=%0d: got ph/rep/rem/busy/done=%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d",
                     cyc, a[22:20], a[19:18], a[17:2], a[1], a[0], e[22:20], e[19:18], e[17:2], e[1], e[0]);
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_cycle(input int r, input bit d);
        start    = 1'b1;
        reps     = 2'(r);
        dry_wash = d;
        cyc      = 0;
        tick();
        start    = 1'b0;
    endtask

    task automatic abort_and_settle();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        run(DRAIN_T + 2);
    endtask

    typedef struct {
        logic        rst, start;
        logic [1:0]  reps;
        logic        dry, pause, abrt;
        logic [2:0]  ph;
        logic        busy, done;
        logic [15:0] rem;
    } vec_t;

    function automatic vec_t mk(int r, int s, int rp, int d, int p, int a, int ph, int b, int dn, int rem);
        vec_t v;
        v.rst = 1'(r); v.start = 1'(s); v.reps = 2'(rp); v.dry = 1'(d);
        v.pause = 1'(p); v.abrt = 1'(a); v.ph = 3'(ph); v.busy = 1'(b);
        v.done = 1'(dn); v.rem = 16'(rem);
        return v;
    endfunction

    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; reps = 2'd1; dry_wash = 1'b0; time_pause = 1'b0; abort = 1'b0;

        // Reset held with start high, release into FILL, pause, abort, DRAIN ignoring start/pause/abort.
        for (int i = 0; i < 5; i++) tbl[i] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 1, 0, 0, 0, 1, 1, 0, 10);
        tbl[6]  = mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 9);
        tbl[7]  = mk(0, 0, 1, 0, 1, 0, 1, 1, 0, 9);
        tbl[8]  = mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 8);
        tbl[9]  = mk(0, 0, 1, 0, 0, 1, 7, 1, 0, 15);
        tbl[10] = mk(0, 1, 1, 0, 1, 0, 7, 1, 0, 14);
        tbl[11] = mk(0, 0, 1, 0, 0, 1, 7, 1, 0, 13);

        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].rst; start = tbl[i].start; reps = tbl[i].reps;
            dry_wash = tbl[i].dry; time_pause = tbl[i].pause; abort = tbl[i].abrt;
            tick();
            chk($sformatf("tbl%0d", i), 32'({phase, busy, done, remaining}),
                32'({tbl[i].ph, tbl[i].busy, tbl[i].done, tbl[i].rem}));
        end
        start = 1'b0; time_pause = 1'b0; abort = 1'b0;
        run(DRAIN_T);
        chk("drain_idle", 32'({phase, busy, done}), 32'({3'd0, 1'b0, 1'b0}));

        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_in_idle", 32'({phase, busy}), 32'({3'd0, 1'b0}));

        // Default single-repetition programme timing.
        start_cycle(1, 0);
        chk("b_fill_first", 32'({phase, remaining}), 32'({3'd1, 16'd10}));
        run_to(10);
        chk("b_fill_last", 32'({phase, remaining}), 32'({3'd1, 16'd1}));
        run_to(11);
        chk("b_wash", 32'({phase, remaining}), 32'({3'd2, 16'd50}));
        run_to(111);
        chk("b_spin", 32'(phase), 32'd4);
        run_to(131);
        chk("b_dry", 32'(phase), 32'd5);
        run_to(191);
        chk("b_done", 32'({phase, busy, done}), 32'({3'd0, 1'b0, 1'b1}));

        // Three repetitions; the MAX_REPS=2 instance clamps to two.
        start_cycle(3, 0);
        run_to(211);
        chk("c_wash2", 32'({phase, rep_idx}), 32'({3'd2, 2'd2}));
        chk("c_clamp_spin", 32'({phase2, rep_idx2}), 32'({3'd4, 2'd1}));
        run_to(311);
        chk("c_spin", 32'({phase, rep_idx}), 32'({3'd4, 2'd2}));
        run_to(391);
        chk("c_done", 32'({phase, done}), 32'({3'd0, 1'b1}));

        // reps=0 behaves as one repetition.
        start_cycle(0, 0);
        run_to(111);
        chk("d_spin", 32'(phase), 32'd4);
        run_to(191);
        chk("d_done", 32'({phase, done}), 32'({3'd0, 1'b1}));

        // Steam clean, sticky done, cleared by the next accepted start.
        start_cycle(2, 1);
        chk("e_steam_first", 32'({phase, remaining}), 32'({3'd6, 16'd60}));
        run_to(60);
        chk("e_steam_last", 32'({phase, remaining}), 32'({3'd6, 16'd1}));
        run_to(61);
        chk("e_done", 32'({phase, busy, done}), 32'({3'd0, 1'b0, 1'b1}));
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("e_done_sticky", 32'(done), 32'd1);
        end
        start_cycle(1, 0);
        chk("e_done_clear", 32'({phase, done}), 32'({3'd1, 1'b0}));
        abort_and_settle();

        // Pause three cycles at WASH counter 4.
        start_cycle(1, 0);
        run_to(15);
        chk("f_pre_pause", 32'({phase, remaining}), 32'({3'd2, 16'd46}));
        time_pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("f_paused", 32'({phase, remaining}), 32'({3'd2, 16'd46}));
        end
        time_pause = 1'b0;
        run_to(63);
        chk("f_wash_end", 32'({phase, remaining}), 32'({3'd2, 16'd1}));
        run_to(64);
        chk("f_rinse", 32'(phase), 32'd3);
        abort_and_settle();

        // Abort with pause at WASH counter 20; DRAIN runs despite pause.
        start_cycle(1, 0);
        run_to(31);
        chk("g_pre_abort", 32'({phase, remaining}), 32'({3'd2, 16'd30}));
        time_pause = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("g_drain", 32'({phase, remaining}), 32'({3'd7, 16'd15}));
        run_to(46);
        chk("g_drain_last", 32'({phase, remaining}), 32'({3'd7, 16'd1}));
        run_to(47);
        chk("g_idle", 32'({phase, busy, done}), 32'({3'd0, 1'b0, 1'b0}));
        time_pause = 1'b0;

        // Asynchronous reset in SPIN takes effect before the next edge.
        start_cycle(1, 0);
        run_to(115);
        chk("h_spin", 32'(phase), 32'd4);
        rst = 1'b1;
        #1;
        chk("h_async_rst", 32'({phase, busy, done, remaining}), 32'({3'd0, 1'b0, 1'b0, 16'd0}));
        model_reset();
        tick();
        rst = 1'b0;
        tick();

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            start      = ($urandom_range(15) == 0);
            reps       = 2'($urandom_range(3));
            dry_wash   = ($urandom_range(3) == 0);
            time_pause = ($urandom_range(7) == 0);
            abort      = ($urandom_range(299) == 0);
            rst        = ($urandom_range(1999) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; time_pause = 1'b0; abort = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
